univ_shift_reg: RTL and testbench
=================================

Name: univ_shift_reg

Overview:
- Parametrised universal register, successor to the single-bit d_latch/dff_asyn/dff_syn storage cells.
- WIDTH-bit storage with hold, shift-left, shift-right, rotate and parallel-load modes, a clock enable and serial in/out on both ends.
- A shift counter and done flag let the block act as a serialiser/deserialiser in the datapath.

Parameters:
- WIDTH, 8, register width in bits; legal range >= 2.
- RST_VAL, {WIDTH{1'b0}}, value loaded into q on reset.
- CNT_W, $clog2(WIDTH+1), shift-counter width; derived, not overridden.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous active-high reset.
- en  input  1  clock enable; when 0, all state holds regardless of mode.
- mode  input  2  operation: 00 hold, 01 shift left, 10 shift right, 11 parallel load.
- rot  input  1  when 1, shifts rotate and sin_l/sin_r are ignored.
- sin_l  input  1  serial input, enters LSB on shift left.
- sin_r  input  1  serial input, enters MSB on shift right.
- d  input  WIDTH  parallel load data.
- q  output  WIDTH  register contents.
- sout_l  output  1  q[WIDTH-1], combinational from q.
- sout_r  output  1  q[0], combinational from q.
- cnt  output  CNT_W  shifts performed since last load or reset.
- done  output  1  high when cnt == WIDTH.

Behaviour:
- Reset: on the rising edge with rst=1, q<=RST_VAL and cnt<=0. rst overrides en and mode. done=0 and sout_* follow RST_VAL the cycle after. A reset mid-shift-sequence discards progress.
- All updates are synchronous, with one-cycle latency: the new q is visible after the edge on which mode/en were sampled.
- en=0: q and cnt hold.
- en=1, mode=00: q and cnt hold.
- en=1, mode=11: q<=d, cnt<=0. rot is ignored.
- en=1, mode=01, rot=0: q<={q[WIDTH-2:0], sin_l}.
- en=1, mode=01, rot=1: q<={q[WIDTH-2:0], q[WIDTH-1]}.
- en=1, mode=10, rot=0: q<={sin_r, q[WIDTH-1:1]}.
- en=1, mode=10, rot=1: q<={q[0], q[WIDTH-1:1]}.
- Counter: on every shift (mode 01 or 10 with en=1), cnt<=cnt+1, saturating at WIDTH. Direction does not matter. Rotates count.
- done: combinational cnt==WIDTH. Stays high until a load or reset. Shifting continues normally while done=1, and cnt stays at WIDTH.
- Simultaneous events have strict priority: rst > en=0 > mode decode.
- No X propagation: mode is fully decoded. Unknown inputs are not specified.

Decomposition:
- Shared package: mode encodings MODE_HOLD=2'b00, MODE_SHL=2'b01, MODE_SHR=2'b10, MODE_LOAD=2'b11, reused by the serdes controller.
- One natural sub-module: sat_counter, a parametrised saturating up-counter with sync clear and increment enable. Reused for cnt.
- The register-next-value mux stays in the top module.

Test Plan:
1. Reset and hold: assert rst for 2 cycles with en=1, mode=11, d=8'hFF. Require q=8'h00, cnt=0, done=0. Then en=0, mode=11 for 3 cycles: q stays 8'h00.
2. Load then shift left: load d=8'hA5, then 8 cycles mode=01, rot=0, sin_l=1. Required q sequence is 8'h4B, 97, 2F, 5F, BF, 7F, FF, FF. cnt goes 1..8, and done=1 after the 8th edge.
3. Rotate right: load 8'h81, then mode=10, rot=1, sin_r=0 for 3 cycles. Require q=8'hC0, 60, 30. sin_r is ignored, and cnt=3.
4. Deserialise: load 8'h00, then shift right 8 cycles with sin_r sequence 1,0,1,1,0,0,1,0. Require q=8'h4D and done=1. A 9th shift keeps cnt=8.
5. Enable gating: after loading 8'h3C, hold en=0 with mode=01 for 4 cycles. Require q=8'h3C and cnt=0. Then 1 shift with en=1 gives q=8'h78, cnt=1.
6. Reset mid-operation: load 8'hF0, shift left 3 cycles (cnt=3), then assert rst together with mode=11. Require q=RST_VAL and cnt=0 on the next edge, with no load of d.

Source files
------------

// File: rtl/univ_shift_reg_pkg.sv
// univ_shift_reg_pkg: mode encodings shared by the shift register and serdes control.
package univ_shift_reg_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHL  = 2'b01,
        MODE_SHR  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;

endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter with sync clear and increment enable, saturating at MAX.
module sat_counter #(
    parameter int MAX = 8,
    parameter int W   = $clog2(MAX + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb cnt_d = clr_i ? '0 : (inc_i && cnt_q != W'(MAX)) ? cnt_q + 1'b1 : cnt_q;

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/univ_shift_reg.sv
// univ_shift_reg: WIDTH-bit hold/shift/rotate/load register with saturating shift counter.
module univ_shift_reg
    import univ_shift_reg_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}},
    parameter int               CNT_W   = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             rot,
    input  logic             sin_l,
    input  logic             sin_r,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             sout_l,
    output logic             sout_r,
    output logic [CNT_W-1:0] cnt,
    output logic             done
);

    logic [WIDTH-1:0] q_q, q_d;
    logic             shl, shr, ld;

    assign shl = en && mode == MODE_SHL;
    assign shr = en && mode == MODE_SHR;
    assign ld  = en && mode == MODE_LOAD;

    always_comb begin
        q_d = q_q;
        if (ld)  q_d = d;
        if (shl) q_d = {q_q[WIDTH-2:0], rot ? q_q[WIDTH-1] : sin_l};
        if (shr) q_d = {rot ? q_q[0] : sin_r, q_q[WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (rst) q_q <= RST_VAL;
        else     q_q <= q_d;
    end

    sat_counter #(.MAX(WIDTH), .W(CNT_W)) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (ld),
        .inc_i (shl || shr),
        .cnt_o (cnt)
    );

    assign q      = q_q;
    assign sout_l = q_q[WIDTH-1];
    assign sout_r = q_q[0];
    assign done   = cnt == CNT_W'(WIDTH);

endmodule

// File: tb/tb_univ_shift_reg.sv
// tb_univ_shift_reg: directed plan plus random stimulus checked against an arithmetic model.
module tb_univ_shift_reg;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1, en = 1'b0, rot = 1'b0, sin_l = 1'b0, sin_r = 1'b0;
    logic [1:0]   mode = 2'b00;
    logic [W-1:0] d = '0;
    logic [W-1:0] q;
    logic         sout_l, sout_r, done;
    logic [3:0]   cnt;

    int n_cmp = 0, n_bad = 0;
    int mq = 0, mc = 0;
    bit live = 0;

    always #5 clk = ~clk;

    univ_shift_reg #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .rot(rot),
        .sin_l(sin_l), .sin_r(sin_r), .d(d), .q(q),
        .sout_l(sout_l), .sout_r(sout_r), .cnt(cnt), .done(done)
    );

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (live) begin
            chk("q", 32'(q), 32'(mq));
            chk("cnt", 32'(cnt), 32'(mc));
            chk("done", 32'(done), 32'(mc == W));
            chk("sout_l", 32'(sout_l), 32'((mq >> (W - 1)) & 1));
            chk("sout_r", 32'(sout_r), 32'(mq & 1));
        end
    end

    task automatic step(input bit r, input bit e, input int m, input bit ro,
                        input bit sl, input bit sr, input int dd);
        rst = r; en = e; mode = 2'(m); rot = ro; sin_l = sl; sin_r = sr; d = W'(dd);
        @(posedge clk);
        if (r) begin
            mq = 0; mc = 0;
        end else if (e && m == 3) begin
            mq = dd; mc = 0;
        end else if (e && (m == 1 || m == 2)) begin
            if (m == 1) mq = (mq * 2 + (ro ? mq / (1 << (W - 1)) : int'(sl))) % (1 << W);
            else        mq = mq / 2 + (1 << (W - 1)) * (ro ? mq % 2 : int'(sr));
            mc = (mc < W) ? mc + 1 : W;
        end
        live = 1;
        @(negedge clk);
    endtask

    task automatic load(input int v);
        step(0, 1, 3, 0, 0, 0, v);
    endtask

    initial begin
        logic [7:0] e2[8] = '{8'h4B, 8'h97, 8'h2F, 8'h5F, 8'hBF, 8'h7F, 8'hFF, 8'hFF};
        logic [7:0] e3[3] = '{8'hC0, 8'h60, 8'h30};
        bit         b4[8] = '{1, 0, 1, 1, 0, 0, 1, 0};

        step(1, 1, 3, 0, 0, 0, 'hFF);
        step(1, 1, 3, 0, 0, 0, 'hFF);
        chk("t1_q", 32'(q), 0); chk("t1_cnt", 32'(cnt), 0); chk("t1_done", 32'(done), 0);
        repeat (3) step(0, 0, 3, 0, 0, 0, 'hFF);
        chk("t1_hold_q", 32'(q), 0);

        load('hA5);
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 1, 0, 1, 0, 0);
            chk("t2_q", 32'(q), 32'(e2[i]));
            chk("t2_cnt", 32'(cnt), 32'(i + 1));
        end
        chk("t2_done", 32'(done), 1);

        load('h81);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 2, 1, 0, 0, 0);
            chk("t3_q", 32'(q), 32'(e3[i]));
        end
        chk("t3_cnt", 32'(cnt), 3);

        load('h00);
        for (int i = 0; i < 8; i++) step(0, 1, 2, 0, 0, b4[i], 0);
        chk("t4_q", 32'(q), 'h4D); chk("t4_done", 32'(done), 1);
        step(0, 1, 2, 0, 0, 0, 0);
        chk("t4_sat_cnt", 32'(cnt), 8);

        load('h3C);
        repeat (4) step(0, 0, 1, 0, 1, 0, 0);
        chk("t5_q", 32'(q), 'h3C); chk("t5_cnt", 32'(cnt), 0);
        step(0, 1, 1, 0, 0, 0, 0);
        chk("t5_shift_q", 32'(q), 'h78); chk("t5_shift_cnt", 32'(cnt), 1);

        load('hF0);
        repeat (3) step(0, 1, 1, 0, 0, 0, 0);
        chk("t6_cnt", 32'(cnt), 3);
        step(1, 1, 3, 0, 0, 0, 'hAA);
        chk("t6_q", 32'(q), 0); chk("t6_cnt", 32'(cnt), 0);

        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 40) == 0, $urandom_range(0, 3) != 0,
                 (i % 50 < 40) ? $urandom_range(1, 2) : $urandom_range(0, 3),
                 $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 1) == 1, int'($urandom_range(0, 255)));

        live = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
